// File: rtl/risc_v.sv
// Single-cycle RV32I-subset core: one instruction fetched, executed and retired per clock.
// Big-endian byte-addressed data memory with combinational reads and wrap-around addressing.
module risc_v #(
  parameter int DMEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_input [0:255],
  output logic [31:0] x7,
  output logic [31:0] x8,
  output logic [31:0] x9
);

  localparam int AW = (DMEM_BYTES > 1) ? $clog2(DMEM_BYTES) : 1;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic [9:0]  r_pc;
  logic [31:0] r_regs [0:31];
  logic [7:0]  r_dmem [0:DMEM_BYTES-1];

  logic [31:0] w_instr;
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1_idx;
  logic [4:0]  w_rs2_idx;
  logic [2:0]  w_f3;
  logic [31:0] w_rs1;
  logic [31:0] w_rs2;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [9:0]  w_boff;
  logic [9:0]  w_joff;
  logic [9:0]  w_pc_plus4;
  logic [31:0] w_sum_i;
  logic [31:0] w_sum_s;
  logic [31:0] w_addr;
  logic [AW-1:0] w_ba [0:3];
  logic [7:0]  w_rb [0:3];
  logic [31:0] w_op_b;
  logic [4:0]  w_shamt;
  logic [31:0] w_alu;
  logic        w_take;
  logic [31:0] w_ld_data;
  logic        w_ld_valid;
  logic [7:0]  w_sd0;
  logic [7:0]  w_sd1;
  logic        w_rd_we;
  logic [31:0] w_rd_data;
  logic        w_st_en;
  logic [9:0]  w_pc_next;

  assign w_instr    = mem_input[r_pc[9:2]];
  assign w_opcode   = w_instr[6:0];
  assign w_rd       = w_instr[11:7];
  assign w_f3       = w_instr[14:12];
  assign w_rs1_idx  = w_instr[19:15];
  assign w_rs2_idx  = w_instr[24:20];
  assign w_rs1      = r_regs[w_rs1_idx];
  assign w_rs2      = r_regs[w_rs2_idx];

  assign w_imm_i    = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s    = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  // PC is only 10 bits wide, so only the low 10 bits of the branch/jump offsets matter.
  assign w_boff     = {w_instr[29:25], w_instr[11:8], 1'b0};
  assign w_joff     = {w_instr[29:21], 1'b0};
  assign w_pc_plus4 = r_pc + 10'd4;

  assign w_sum_i    = w_rs1 + w_imm_i;
  assign w_sum_s    = w_rs1 + w_imm_s;
  assign w_addr     = (w_opcode == OPC_STORE) ? w_sum_s : w_sum_i;

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign w_ba[gi] = AW'((w_addr + 32'(gi)) % 32'(DMEM_BYTES));
    assign w_rb[gi] = r_dmem[w_ba[gi]];
  end

  assign w_op_b  = (w_opcode == OPC_OP) ? w_rs2 : w_imm_i;
  assign w_shamt = w_op_b[4:0];

  always_comb begin
    w_alu = '0;
    case (w_f3)
      3'b000: begin
        if (w_opcode == OPC_OP && w_instr[30]) w_alu = w_rs1 - w_op_b;
        else                                   w_alu = w_rs1 + w_op_b;
      end
      3'b001: w_alu = w_rs1 << w_shamt;
      3'b010: w_alu = {31'b0, $signed(w_rs1) < $signed(w_op_b)};
      3'b011: w_alu = {31'b0, w_rs1 < w_op_b};
      3'b100: w_alu = w_rs1 ^ w_op_b;
      3'b101: begin
        if (w_instr[30]) w_alu = $signed(w_rs1) >>> w_shamt;
        else             w_alu = w_rs1 >> w_shamt;
      end
      3'b110: w_alu = w_rs1 | w_op_b;
      default: w_alu = w_rs1 & w_op_b;
    endcase
  end

  always_comb begin
    w_take = 1'b0;
    case (w_f3)
      3'b000:  w_take = (w_rs1 == w_rs2);
      3'b001:  w_take = (w_rs1 != w_rs2);
      3'b100:  w_take = ($signed(w_rs1) < $signed(w_rs2));
      3'b101:  w_take = !($signed(w_rs1) < $signed(w_rs2));
      3'b110:  w_take = (w_rs1 < w_rs2);
      3'b111:  w_take = !(w_rs1 < w_rs2);
      default: w_take = 1'b0;
    endcase
  end

  // Big-endian: the lowest address supplies the most significant byte.
  always_comb begin
    w_ld_data  = '0;
    w_ld_valid = 1'b1;
    case (w_f3)
      3'b000:  w_ld_data = {{24{w_rb[0][7]}}, w_rb[0]};
      3'b001:  w_ld_data = {{16{w_rb[0][7]}}, w_rb[0], w_rb[1]};
      3'b010:  w_ld_data = {w_rb[0], w_rb[1], w_rb[2], w_rb[3]};
      3'b100:  w_ld_data = {24'b0, w_rb[0]};
      3'b101:  w_ld_data = {16'b0, w_rb[0], w_rb[1]};
      default: w_ld_valid = 1'b0;
    endcase
  end

  assign w_sd0 = (w_f3 == 3'b000) ? w_rs2[7:0] :
                 (w_f3 == 3'b001) ? w_rs2[15:8] : w_rs2[31:24];
  assign w_sd1 = (w_f3 == 3'b001) ? w_rs2[7:0] : w_rs2[23:16];

  always_comb begin
    w_rd_we   = 1'b0;
    w_rd_data = '0;
    w_st_en   = 1'b0;
    w_pc_next = w_pc_plus4;
    case (w_opcode)
      OPC_OPIMM, OPC_OP: begin
        w_rd_we   = 1'b1;
        w_rd_data = w_alu;
      end
      OPC_LUI: begin
        // Keeps the low 12 bits so ADDI followed by LUI builds a full constant.
        w_rd_we   = 1'b1;
        w_rd_data = {w_instr[31:12], r_regs[w_rd][11:0]};
      end
      OPC_LOAD: begin
        w_rd_we   = w_ld_valid;
        w_rd_data = w_ld_data;
      end
      OPC_STORE: begin
        w_st_en = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010);
      end
      OPC_BRANCH: begin
        if (w_take) w_pc_next = (r_pc + w_boff) & 10'h3FC;
      end
      OPC_JAL: begin
        w_rd_we   = 1'b1;
        w_rd_data = {22'b0, w_pc_plus4};
        w_pc_next = (r_pc + w_joff) & 10'h3FC;
      end
      OPC_JALR: begin
        if (w_f3 == 3'b000) begin
          w_rd_we   = 1'b1;
          w_rd_data = {22'b0, w_pc_plus4};
          w_pc_next = 10'(w_sum_i) & 10'h3FC;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= '0;
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (w_rd_we && w_rd != 5'd0) r_regs[w_rd] <= w_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DMEM_BYTES; i++) r_dmem[i] <= '0;
    end else if (w_st_en) begin
      r_dmem[w_ba[0]] <= w_sd0;
      if (w_f3 != 3'b000) r_dmem[w_ba[1]] <= w_sd1;
      if (w_f3 == 3'b010) begin
        r_dmem[w_ba[2]] <= w_rs2[15:8];
        r_dmem[w_ba[3]] <= w_rs2[7:0];
      end
    end
  end

  assign x7 = r_regs[7];
  assign x8 = r_regs[8];
  assign x9 = r_regs[9];

endmodule

// File: tb/tb_risc_v.sv
// Directed-program bench for risc_v: loads small hand-assembled programs and checks x7/x8/x9.
module tb_risc_v;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] imem [0:255];
  logic [31:0] x7, x8, x9;
  int vectors = 0;
  int miscompares = 0;

  risc_v #(.DMEM_BYTES(256)) dut (
    .clk(clk), .rst(rst), .mem_input(imem), .x7(x7), .x8(x8), .x9(x9)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] i_type(input logic [6:0] opc, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return i_type(7'h13, 3'b000, rd, rs1, imm);
  endfunction

  function automatic logic [31:0] lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'h37};
  endfunction

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] s_type(input logic [2:0] f3, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] b_type(input logic [2:0] f3, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [12:0] off);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'h63};
  endfunction

  function automatic logic [31:0] jal(input logic [4:0] rd, input logic [20:0] off);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6F};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Setup, stores, then BEQ x5,x6 picks one of two load triples; both paths end at idx 22.
  task automatic load_string(input logic [11:0] x6_val);
    clear_imem();
    imem[0]  = addi(5'd1, 5'd0, 12'hC6C);  imem[1] = lui(5'd1, 20'h48656);
    imem[2]  = addi(5'd2, 5'd0, 12'h76F);  imem[3] = lui(5'd2, 20'h6F207);
    imem[4]  = addi(5'd3, 5'd0, 12'h421);  imem[5] = lui(5'd3, 20'h726C6);
    imem[6]  = addi(5'd4, 5'd0, 12'h520);  imem[7] = lui(5'd4, 20'h42796);
    imem[8]  = s_type(3'b010, 5'd1, 5'd0, 12'd0);
    imem[9]  = s_type(3'b010, 5'd2, 5'd0, 12'd4);
    imem[10] = s_type(3'b010, 5'd3, 5'd0, 12'd8);
    imem[11] = s_type(3'b010, 5'd4, 5'd0, 12'd12);
    imem[12] = addi(5'd5, 5'd0, 12'd2);
    imem[13] = addi(5'd6, 5'd0, x6_val);
    imem[14] = b_type(3'b000, 5'd5, 5'd6, 13'd20);
    imem[15] = i_type(7'h03, 3'b010, 5'd7, 5'd0, 12'd12);
    imem[16] = i_type(7'h03, 3'b010, 5'd8, 5'd0, 12'd6);
    imem[17] = i_type(7'h03, 3'b101, 5'd9, 5'd0, 12'd10);
    imem[18] = jal(5'd0, 21'd16);
    imem[19] = i_type(7'h03, 3'b010, 5'd7, 5'd0, 12'd0);
    imem[20] = i_type(7'h03, 3'b010, 5'd8, 5'd0, 12'd4);
    imem[21] = i_type(7'h03, 3'b010, 5'd9, 5'd0, 12'd8);
    imem[22] = jal(5'd0, 21'd0);
  endtask

  initial begin
    clear_imem();
    imem[0] = addi(5'd7, 5'd0, 12'hC6C);
    imem[1] = lui(5'd7, 20'h48656);
    imem[2] = addi(5'd8, 5'd0, 12'h123);
    imem[3] = lui(5'd8, 20'hABCDE);
    imem[4] = jal(5'd0, 21'd0);

    // 1: reset state and first-edge execution
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_x7", x7, 32'h0);
    check("reset_x8", x8, 32'h0);
    check("reset_x9", x9, 32'h0);
    rst = 1'b1;
    run(1);
    check("first_edge_x7", x7, 32'hFFFFFC6C);

    // 2: constant build
    run(3);
    check("const_x7", x7, 32'h48656C6C);
    check("const_x8", x8, 32'hABCDE123);

    // 3: string program, branch not taken
    hold_reset(); load_string(12'd6); release_reset();
    run(30);
    check("str_nt_x7", x7, 32'h42796520);
    check("str_nt_x8", x8, 32'h776F726C);
    check("str_nt_x9", x9, 32'h00006421);

    // 4: string program, branch taken
    hold_reset(); load_string(12'd2); release_reset();
    run(30);
    check("str_tk_x7", x7, 32'h48656C6C);
    check("str_tk_x8", x8, 32'h6F20776F);
    check("str_tk_x9", x9, 32'h726C6421);

    // 5: byte sign/zero extension and x0 immutability
    hold_reset();
    clear_imem();
    imem[0] = addi(5'd1, 5'd0, 12'hF80);
    imem[1] = s_type(3'b000, 5'd1, 5'd0, 12'd20);
    imem[2] = i_type(7'h03, 3'b000, 5'd7, 5'd0, 12'd20);
    imem[3] = i_type(7'h03, 3'b100, 5'd8, 5'd0, 12'd20);
    imem[4] = addi(5'd0, 5'd0, 12'd5);
    imem[5] = addi(5'd9, 5'd0, 12'd1);
    imem[6] = jal(5'd0, 21'd0);
    release_reset();
    run(10);
    check("lb_x7", x7, 32'hFFFFFF80);
    check("lbu_x8", x8, 32'h00000080);
    check("x0_plus1_x9", x9, 32'h00000001);

    // 6: reset mid-run clears registers and memory, then the program reruns
    hold_reset(); load_string(12'd6); release_reset();
    run(17);
    check("midrun_pre_x7", x7, 32'h42796520);
    rst = 1'b0;
    #2;
    check("midrun_async_x7", x7, 32'h0);
    check("midrun_async_x8", x8, 32'h0);
    check("midrun_async_x9", x9, 32'h0);
    clear_imem();
    imem[0] = i_type(7'h03, 3'b010, 5'd7, 5'd0, 12'd0);
    imem[1] = i_type(7'h03, 3'b010, 5'd8, 5'd0, 12'd4);
    imem[2] = i_type(7'h03, 3'b010, 5'd9, 5'd0, 12'd8);
    imem[3] = jal(5'd0, 21'd0);
    release_reset();
    run(8);
    check("dmem_clr_x7", x7, 32'h0);
    check("dmem_clr_x8", x8, 32'h0);
    check("dmem_clr_x9", x9, 32'h0);
    hold_reset(); load_string(12'd6); release_reset();
    run(30);
    check("rerun_x7", x7, 32'h42796520);
    check("rerun_x8", x8, 32'h776F726C);
    check("rerun_x9", x9, 32'h00006421);

    // 7: SRA / SRL / SUB
    hold_reset();
    clear_imem();
    imem[0] = addi(5'd1, 5'd0, 12'hFF0);
    imem[1] = addi(5'd2, 5'd0, 12'd3);
    imem[2] = r_type(7'h20, 3'b101, 5'd7, 5'd1, 5'd2);
    imem[3] = r_type(7'h00, 3'b101, 5'd8, 5'd1, 5'd2);
    imem[4] = r_type(7'h20, 3'b000, 5'd9, 5'd2, 5'd1);
    imem[5] = jal(5'd0, 21'd0);
    release_reset();
    run(8);
    check("sra_x7", x7, 32'hFFFFFFFE);
    check("srl_x8", x8, 32'h1FFFFFFE);
    check("sub_x9", x9, 32'h00000013);

    // 8: SLT / SLTU / SLL
    hold_reset();
    imem[2] = r_type(7'h00, 3'b010, 5'd7, 5'd1, 5'd2);
    imem[3] = r_type(7'h00, 3'b011, 5'd8, 5'd1, 5'd2);
    imem[4] = r_type(7'h00, 3'b001, 5'd9, 5'd2, 5'd2);
    release_reset();
    run(8);
    check("slt_x7", x7, 32'h00000001);
    check("sltu_x8", x8, 32'h00000000);
    check("sll_x9", x9, 32'h00000018);

    // 9: SH/LHU/LW across the address wrap, BLT not taken, JALR alignment
    hold_reset();
    clear_imem();
    imem[0] = addi(5'd1, 5'd0, 12'h7AB);
    imem[1] = s_type(3'b001, 5'd1, 5'd0, 12'd255);
    imem[2] = i_type(7'h03, 3'b101, 5'd7, 5'd0, 12'd255);
    imem[3] = i_type(7'h03, 3'b010, 5'd8, 5'd0, 12'd254);
    imem[4] = b_type(3'b100, 5'd1, 5'd0, 13'd8);
    imem[5] = i_type(7'h67, 3'b000, 5'd9, 5'd0, 12'd30);
    imem[6] = addi(5'd7, 5'd0, 12'd1);
    imem[7] = jal(5'd0, 21'd0);
    release_reset();
    run(12);
    check("wrap_lhu_x7", x7, 32'h000007AB);
    check("wrap_lw_x8", x8, 32'h0007AB00);
    check("jalr_link_x9", x9, 32'h00000018);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/risc_v.md
Name: risc_v

Overview:
- Single-cycle RV32I-subset processor: every rising clock edge fetches, executes and retires one instruction.
- Instruction memory is a 256-word array supplied on an input port.
- Data memory is internal.
- Registers x7, x8 and x9 are exported so the system can observe results directly.

Parameters:
DMEM_BYTES, 256, data memory size in bytes; byte address wraps modulo DMEM_BYTES.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous active-low reset.
mem_input  input  32 x [0:255] (unpacked array)  instruction memory; word i is at byte address 4*i.
x7  output  32  live value of register x7.
x8  output  32  live value of register x8.
x9  output  32  live value of register x9.

Behaviour:
- Reset (rst=0, asynchronous):
  - PC=0.
  - All 32 registers = 0, so x7=x8=x9=0.
  - All data memory bytes = 0.
  - Held while rst=0. Asserting reset mid-program aborts the program immediately; execution restarts at PC=0.
- Fetch: instr = mem_input[PC[9:2]]. PC is always word-aligned. PC arithmetic is modulo 1024, so it wraps.
- Execution timing:
  - The first rising edge after rst deasserts executes mem_input[0].
  - Register and memory writes become visible after the edge that executes the instruction.
  - x7/x8/x9 are combinational copies of the register file.
- x0 reads 0; writes to x0 are discarded.
- Supported instructions:
  - OP-IMM (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
    - imm = sign-extended instr[31:20].
  - OP (0110011): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - LUI (0110111): rd[31:12] = instr[31:12]; rd[11:0] is preserved.
    - This is a deliberate deviation from RV32I. An ADDI followed by a LUI to the same rd builds a full 32-bit constant.
  - LOAD (0000011), address = rs1 + sext(imm):
    - LB (000) and LH (001) sign-extend.
    - LW (010) returns the full word.
    - LBU (100) and LHU (101) zero-extend.
  - STORE (0100011): SB (000), SH (001), SW (010); imm = {instr[31:25], instr[11:7]}, sign-extended.
  - BRANCH (1100011): BEQ, BNE, BLT, BGE, BLTU, BGEU.
    - Offset = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
    - Taken: PC += offset. Not taken: PC += 4.
  - JAL (1101111): rd = PC+4; PC += sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - JALR (1100111): rd = PC+4; PC = (rs1 + sext(imm)) & ~1, then forced word-aligned.
- Any other opcode or funct3 is a NOP: no writes, PC += 4.
- Data memory:
  - Byte-addressed, big-endian: the byte at address a is the most significant byte of a word access at a.
  - Misaligned halfword and word accesses are fully supported: consecutive byte addresses, each wrapping modulo DMEM_BYTES. No traps.
  - Writes are synchronous. Reads are combinational, so a load in the cycle after a store sees the stored data.
- Arithmetic: all 32-bit, overflow wraps. Shifts use the low 5 bits of the shift amount.

Test Plan:
1. Reset: hold rst=0 for 5 cycles -> x7=x8=x9=0. Release; the first edge executes word 0.
2. Constant build: ADDI x7,x0,0xC6C; LUI x7,0x48656 -> x7=0x48656C6C. ADDI x8,x0,0x123; LUI x8,0xABCDE -> x8=0xABCDE123.
3. String program:
   - Setup: x1..x4 = 0x48656C6C, 0x6F20776F, 0x726C6421, 0x42796520; SW them to addresses 0/4/8/12; ADDI x5=2, ADDI x6=6.
   - Then: BEQ x5,x6,+20 (not taken); LW x7,12(x0); LW x8,6(x0); LHU x9,10(x0); JAL x0,+16.
   - Within 25 cycles -> x7=0x42796520, x8=0x776F726C, x9=0x00006421.
4. Same program with x6=2 (branch taken) to LW x7,0 / LW x8,4 / LW x9,8 -> x7=0x48656C6C, x8=0x6F20776F, x9=0x726C6421.
5. Sign/zero extension: ADDI x1,x0,-128; SB x1,20(x0); LB x7,20(x0); LBU x8,20(x0) -> x7=0xFFFFFF80, x8=0x00000080. Also ADDI x0,x0,5 -> x0 stays 0.
6. Reset mid-run: assert rst=0 during test 3 after the SWs -> x7=x8=x9=0 and memory cleared. On release the program reruns and gives the test 3 values.
